// File: rtl/regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module   : regfile8x16
//  Brief    : 8x16 register file, 2 combinational reads, 1 sync write, with a
//             per-register pending-write scoreboard. R0 reads as zero.
//             Optional macro REGFILE_BYPASS_EN enables write-through forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module regfile8x16 #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic              busy_a,
   output logic              busy_b,
   output logic              stall
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic              w_wr_ok;

   assign w_wr_ok = wr_en && (wr_addr != '0);

   // Set beats clear on the same address: a new producer was just issued.
   always_comb begin
      pend_d = pend_q;
      for (int i = 1; i < NREG; i++) begin
         if (busy_set && (busy_addr == ADDR_W'(i))) begin
            pend_d[i] = 1'b1;
         end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
            pend_d[i] = 1'b0;
         end
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         if (w_wr_ok) begin
            regs_q[wr_addr] <= wr_data;
         end
         pend_q <= pend_d;
      end
   end

   logic [DATA_W-1:0] w_stored_a;
   logic [DATA_W-1:0] w_stored_b;
   logic              w_pend_a;
   logic              w_pend_b;

   assign w_stored_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
   assign w_stored_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
   assign w_pend_a   = pend_q[rd_addr_a];
   assign w_pend_b   = pend_q[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   assign w_byp_a   = w_wr_ok && (wr_addr == rd_addr_a);
   assign w_byp_b   = w_wr_ok && (wr_addr == rd_addr_b);
   assign rd_data_a = w_byp_a ? wr_data : w_stored_a;
   assign rd_data_b = w_byp_b ? wr_data : w_stored_b;
   assign busy_a    = w_pend_a && !w_byp_a;
   assign busy_b    = w_pend_b && !w_byp_b;
`else
   assign rd_data_a = w_stored_a;
   assign rd_data_b = w_stored_b;
   assign busy_a    = w_pend_a;
   assign busy_b    = w_pend_b;
`endif

   assign stall = busy_a | busy_b;

endmodule
`default_nettype wire

// File: tb/tb_regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile8x16
//  Brief    : Self-checking bench for regfile8x16 against an array-based model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/100ps
module tb_regfile8x16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, busy_addr;
   logic [15:0] rd_data_a, rd_data_b, wr_data;
   logic        wr_en, busy_set, busy_a, busy_b, stall;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_regs [8];
   bit          m_pend [8];

   always #5 clk = ~clk;

   regfile8x16 #(.DATA_W(16), .ADDR_W(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_b (rd_data_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_set  (busy_set),
      .busy_addr (busy_addr),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .stall     (stall)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit fwd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
      return wr_en && (wr_addr != 0) && (wr_addr == a);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] exp_data(input logic [2:0] a);
      if (a == 0) return 16'h0000;
      if (fwd(a)) return wr_data;
      return m_regs[a];
   endfunction

   function automatic bit exp_busy(input logic [2:0] a);
      if (a == 0 || fwd(a)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic check_all();
      bit ba, bb;
      ba = exp_busy(rd_addr_a);
      bb = exp_busy(rd_addr_b);
      chk("rd_data_a", rd_data_a, exp_data(rd_addr_a));
      chk("rd_data_b", rd_data_b, exp_data(rd_addr_b));
      chk("busy_a", {15'd0, busy_a}, {15'd0, ba});
      chk("busy_b", {15'd0, busy_b}, {15'd0, bb});
      chk("stall", {15'd0, stall}, {15'd0, ba | bb});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = 16'h0000;
         m_pend[i] = 1'b0;
      end
   endtask

   // Clear first, then set, so a same-edge set on the written register wins.
   task automatic model_edge();
      if (wr_en && wr_addr != 0) begin
         m_regs[wr_addr] = wr_data;
         m_pend[wr_addr] = 1'b0;
      end
      if (busy_set && busy_addr != 0) m_pend[busy_addr] = 1'b1;
   endtask

   task automatic cyc(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic bs, input logic [2:0] bsa,
                      input logic [2:0] ra, input logic [2:0] rb);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      busy_set = bs; busy_addr = bsa;
      rd_addr_a = ra; rd_addr_b = rb;
      #1 check_all();
      @(posedge clk);
      model_edge();
   endtask

   task automatic reset_midcycle();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5A5A;
      busy_set = 1'b1; busy_addr = 3'd5;
      rd_addr_a = 3'd3; rd_addr_b = 3'd5;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_rd_a", rd_data_a, 16'h0000);
      chk("rst_rd_b", rd_data_b, 16'h0000);
      chk("rst_busy", {14'd0, busy_a, busy_b}, 16'h0000);
      chk("rst_stall", {15'd0, stall}, 16'h0000);
      @(posedge clk);
      #1;
      wr_en = 1'b0; busy_set = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
         #0.5;
         chk("rst_sweep_a", rd_data_a, 16'h0000);
         chk("rst_sweep_b", rd_data_b, 16'h0000);
         chk("rst_sweep_stall", {15'd0, stall}, 16'h0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 0; wr_addr = 0; wr_data = 0; busy_set = 0; busy_addr = 0;
      rd_addr_a = 3'd3; rd_addr_b = 3'd5;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: basic write/read
      cyc(1, 3, 16'hA5A5, 0, 0, 3, 5);
      cyc(1, 5, 16'h1234, 0, 0, 3, 5);
      cyc(0, 0, 16'h0000, 0, 0, 3, 5);
      chk("dir_r3", rd_data_a, 16'hA5A5);
      chk("dir_r5", rd_data_b, 16'h1234);
      // R0 ignores writes and busy
      cyc(1, 0, 16'hFFFF, 1, 0, 0, 0);
      cyc(0, 0, 16'h0000, 0, 0, 0, 0);
      chk("dir_r0_data", rd_data_a, 16'h0000);
      chk("dir_r0_busy", {15'd0, busy_a}, 16'h0000);
      // Scoreboard
      cyc(0, 0, 16'h0000, 1, 4, 4, 1);
      cyc(0, 0, 16'h0000, 0, 0, 4, 1);
      chk("dir_busy4", {15'd0, busy_a}, 16'h0001);
      chk("dir_stall4", {15'd0, stall}, 16'h0001);
      cyc(1, 4, 16'h00C3, 0, 0, 4, 1);
      cyc(0, 0, 16'h0000, 0, 0, 4, 1);
      chk("dir_clr4", {15'd0, busy_a}, 16'h0000);
      chk("dir_data4", rd_data_a, 16'h00C3);
      cyc(1, 4, 16'h0011, 1, 4, 4, 4);
      cyc(0, 0, 16'h0000, 0, 0, 4, 4);
      chk("dir_setwins", {15'd0, busy_a}, 16'h0001);
      // Bypass / no-bypass on R6 while pending
      cyc(0, 0, 16'h0000, 1, 6, 6, 6);
      cyc(1, 6, 16'hBEEF, 0, 0, 6, 2);
`ifdef REGFILE_BYPASS_EN
      chk("dir_byp_data", rd_data_a, 16'hBEEF);
      chk("dir_byp_busy", {15'd0, busy_a}, 16'h0000);
`else
      chk("dir_nobyp_data", rd_data_a, 16'h0000);
      chk("dir_nobyp_busy", {15'd0, busy_a}, 16'h0001);
`endif
      cyc(0, 0, 16'h0000, 0, 0, 6, 2);
      chk("dir_after_edge", rd_data_a, 16'hBEEF);

      // Randomized traffic, with a mid-operation reset in the middle
      for (int n = 0; n < 400; n++) begin
         if (n == 200) reset_midcycle();
         cyc(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
             1'($urandom_range(0, 3) == 0), 3'($urandom),
             3'($urandom), 3'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
